// File: rtl/ov7670_pkg.sv
// ov7670_pkg: geometry defaults, capture FSM encoding and RGB565 colour-bar palette.
package ov7670_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam bit VS_POL_DEF   = 1'b1;

    typedef enum logic [1:0] {
        SYNC,
        VBLANK,
        ACTIVE
    } state_e;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    localparam logic [15:0] BAR_RGB [8] = '{RGB_WHITE, RGB_YELLOW, RGB_CYAN, RGB_GREEN,
                                            RGB_MAGENTA, RGB_RED, RGB_BLUE, RGB_BLACK};

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        return BAR_RGB[idx];
    endfunction

endpackage

// File: rtl/ov7670_byte_pair.sv
// ov7670_byte_pair: alternates high/low byte phase, latches the high byte and flags a completed pair.
module ov7670_byte_pair
    import ov7670_pkg::*;
(
    input  logic        clk,
    input  logic        sync_rst,
    input  logic        clr_i,
    input  logic        cap_i,
    input  logic [7:0]  data_i,
    output logic        pair_o,
    output logic [15:0] word_o,
    output logic        phase_o
);
    logic       phase_q, phase_d;
    logic [7:0] hi_q, hi_d;

    always_comb begin
        phase_d = clr_i ? 1'b0 : phase_q ^ cap_i;
        hi_d    = (cap_i && !phase_q) ? data_i : hi_q;
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            phase_q <= 1'b0;
            hi_q    <= '0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
        end
    end

    assign pair_o  = cap_i && phase_q;
    assign word_o  = {hi_q, data_i};
    assign phase_o = phase_q;

endmodule

// File: rtl/ov7670_capture.sv
// ov7670_capture: OV7670 byte stream to RGB565 valid-only pixel stream with line/frame geometry checks.
// Define OV7670_TESTPAT_EN to add testpat_sel, which swaps pixel data for 8 vertical colour bars.
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter bit VS_POL   = VS_POL_DEF
) (
    input  logic        clk,
    input  logic        sync_rst,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
`ifdef OV7670_TESTPAT_EN
    input  logic        testpat_sel,
`endif
    input  logic        err_clr,
    output logic        m_tvalid,
    output logic [15:0] m_tdata,
    output logic        m_tuser,
    output logic        m_tlast,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err
);
    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam int RW = $clog2(V_ACTIVE + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] COL_MAX  = CW'(H_ACTIVE);
    localparam logic [RW-1:0] ROW_MAX  = RW'(V_ACTIVE);

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [15:0]   tdata_q, tdata_d, word, pix;
    logic          href_q, ovf_q, ovf_d;
    logic          tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
    logic          done_q, done_d, lerr_q, lerr_d, ferr_q, ferr_d;
    logic          act, vs_act, cap, fall, pair, phase, col_full, row_full, frame_ok, emit;

    assign act      = state_q == ACTIVE;
    assign vs_act   = cam_vsync == VS_POL;
    assign cap      = act && cam_href && !vs_act;
    assign fall     = act && href_q && !cam_href;
    assign col_full = col_q == COL_MAX;
    assign row_full = row_q == ROW_MAX;
    // Extra lines saturate the row counter, so ovf_q keeps them from passing as a good frame.
    assign frame_ok = row_full && !ovf_q;
    assign emit     = pair && !col_full && !row_full;

    ov7670_byte_pair u_pair (
        .clk     (clk),
        .sync_rst(sync_rst),
        .clr_i   (!act || fall),
        .cap_i   (cap),
        .data_i  (cam_data),
        .pair_o  (pair),
        .word_o  (word),
        .phase_o (phase)
    );

`ifdef OV7670_TESTPAT_EN
    localparam int BAR_W = H_ACTIVE / 8;
    assign pix = testpat_sel ? bar_color(3'(col_q / CW'(BAR_W))) : word;
`else
    assign pix = word;
`endif

    always_comb begin
        state_d  = vs_act ? VBLANK : (state_q == SYNC ? SYNC : ACTIVE);
        col_d    = (!act || fall) ? '0 : (pair && !col_full) ? col_q + 1'b1 : col_q;
        row_d    = !act ? '0 : (fall && !row_full) ? row_q + 1'b1 : row_q;
        ovf_d    = act && (ovf_q || (fall && row_full));
        tvalid_d = emit;
        tdata_d  = emit ? pix : tdata_q;
        tuser_d  = emit ? (row_q == '0 && col_q == '0) : tuser_q;
        tlast_d  = emit ? (col_q == COL_LAST) : tlast_q;
        done_d   = act && vs_act && frame_ok;
        lerr_d   = (lerr_q && !err_clr) || (pair && col_full) || (fall && (phase || !col_full));
        ferr_d   = (ferr_q && !err_clr) || (act && vs_act && !frame_ok) || (pair && row_full);
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q  <= SYNC;
            col_q    <= '0;
            row_q    <= '0;
            href_q   <= 1'b0;
            ovf_q    <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
            lerr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            href_q   <= cam_href;
            ovf_q    <= ovf_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
            lerr_q   <= lerr_d;
            ferr_q   <= ferr_d;
        end
    end

    assign m_tvalid   = tvalid_q;
    assign m_tdata    = tdata_q;
    assign m_tuser    = tuser_q;
    assign m_tlast    = tlast_q;
    assign frame_done = done_q;
    assign line_err   = lerr_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: scaled-down frame scenarios with a pixel scoreboard and per-frame count/flag checks.
module tb_ov7670_capture;
    localparam int H = 16;
    localparam int V = 4;
    localparam logic [15:0] PAL [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                        16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    typedef struct packed {
        logic [15:0] data;
        logic        user;
        logic        last;
    } pix_t;

    typedef struct {
        int short_row;
        int long_row;
        int abort_row;
        int extra;
        int clr_row;
        bit tpat;
        int pix;
        int lasts;
        bit done;
        bit lerr;
        bit ferr;
    } vec_t;

    logic        clk = 1'b0, sync_rst = 1'b1, cam_vsync = 1'b0, cam_href = 1'b0, err_clr = 1'b0, tp = 1'b0;
    logic [7:0]  cam_data = '0;
    logic        m_tvalid, m_tuser, m_tlast, frame_done, line_err, frame_err;
    logic [15:0] m_tdata;

    pix_t obs [4096];
    int   n_obs = 0, n_last = 0, n_user = 0, n_done = 0;
    int   rd = 0, n_cmp = 0, n_bad = 0;
    pix_t exp_q [$];
    vec_t vecs [$];

    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .VS_POL(1'b1)) dut (
        .clk       (clk),
        .sync_rst  (sync_rst),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
`ifdef OV7670_TESTPAT_EN
        .testpat_sel(tp),
`endif
        .err_clr   (err_clr),
        .m_tvalid  (m_tvalid),
        .m_tdata   (m_tdata),
        .m_tuser   (m_tuser),
        .m_tlast   (m_tlast),
        .frame_done(frame_done),
        .line_err  (line_err),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_tvalid) begin
            obs[n_obs % 4096] <= {m_tdata, m_tuser, m_tlast};
            n_obs  <= n_obs + 1;
            n_user <= n_user + int'(m_tuser);
            n_last <= n_last + int'(m_tlast);
        end
        if (frame_done) n_done <= n_done + 1;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, req);
        end
    endtask

    task automatic drain(input string tag);
        pix_t e;
        while (rd < n_obs) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s unexpected pixel: got 0x%0h required none", tag, obs[rd % 4096]);
            end else begin
                e = exp_q.pop_front();
                check({tag, " pixel"}, 32'(obs[rd % 4096]), 32'(e));
            end
            rd++;
        end
        check({tag, " missing pixels"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic send_line(input int nbytes, input int r, input bit push, input bit clr_fall, input bit keep_high);
        logic [7:0] hi;
        hi = '0;
        for (int b = 0; b < nbytes; b++) begin
            cam_href = 1'b1;
            cam_data = 8'($urandom_range(0, 255));
            if (b % 2 == 0) hi = cam_data;
            else if (push && r < V && b / 2 < H)
                exp_q.push_back({tp ? PAL[(b / 2) / (H / 8)] : {hi, cam_data}, r == 0 && b == 1, b / 2 == H - 1});
            cyc(1);
        end
        if (!keep_high) begin
            cam_href = 1'b0;
            err_clr  = clr_fall;
            cyc(1);
            err_clr  = 1'b0;
            cyc(2);
        end
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int p0, l0, u0, d0;
        p0 = n_obs;
        l0 = n_last;
        u0 = n_user;
        d0 = n_done;
        tp = v.tpat;
        err_clr = 1'b1;
        cam_vsync = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        cyc(2);
        cam_vsync = 1'b0;
        cyc(2);
        for (int r = 0; r < V + v.extra && r != v.abort_row; r++)
            send_line(r == v.short_row ? 2 * H - 1 : r == v.long_row ? 2 * H + 2 : 2 * H, r, 1'b1, r == v.clr_row, 1'b0);
        cam_vsync = 1'b1;
        cyc(4);
        drain(tag);
        check({tag, " tvalid count"}, n_obs - p0, v.pix);
        check({tag, " tlast count"}, n_last - l0, v.lasts);
        check({tag, " tuser count"}, n_user - u0, 1);
        check({tag, " frame_done count"}, n_done - d0, int'(v.done));
        check({tag, " line_err"}, line_err, v.lerr);
        check({tag, " frame_err"}, frame_err, v.ferr);
        tp = 1'b0;
    endtask

    initial begin
        int u0;
        vecs.push_back('{-1, -1, -1, 0, -1, 1'b0, H * V,     V,     1'b1, 1'b0, 1'b0});
        vecs.push_back('{ 1, -1, -1, 0, -1, 1'b0, H * V - 1, V - 1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{-1, -1, -1, 0, -1, 1'b0, H * V,     V,     1'b1, 1'b0, 1'b0});
        vecs.push_back('{-1, -1,  2, 0, -1, 1'b0, 2 * H,     2,     1'b0, 1'b0, 1'b1});
        vecs.push_back('{-1, -1, -1, 0, -1, 1'b0, H * V,     V,     1'b1, 1'b0, 1'b0});
        vecs.push_back('{-1, -1, -1, 1, -1, 1'b0, H * V,     V,     1'b0, 1'b0, 1'b1});
        vecs.push_back('{-1,  0, -1, 0, -1, 1'b0, H * V,     V,     1'b1, 1'b1, 1'b0});
        vecs.push_back('{ 3, -1, -1, 0,  3, 1'b0, H * V - 1, V - 1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{-1, -1, -1, 0, -1, 1'b0, H * V,     V,     1'b1, 1'b0, 1'b0});
`ifdef OV7670_TESTPAT_EN
        vecs.push_back('{-1, -1, -1, 0, -1, 1'b1, H * V,     V,     1'b1, 1'b0, 1'b0});
`endif
        sync_rst = 1'b1;
        cyc(3);
        sync_rst = 1'b0;
        cyc(1);
        check("reset m_tvalid", m_tvalid, 0);
        check("reset m_tdata", m_tdata, 0);
        check("reset m_tuser/m_tlast", {m_tuser, m_tlast}, 0);
        check("reset frame_done", frame_done, 0);
        check("reset error flags", {line_err, frame_err}, 0);
        send_line(2 * H, 1, 1'b0, 1'b0, 1'b0);
        send_line(2 * H, 2, 1'b0, 1'b0, 1'b0);
        check("partial frame discarded", n_obs, 0);
        foreach (vecs[i]) run_frame(vecs[i], $sformatf("vec%0d", i));
        err_clr = 1'b1;
        cam_vsync = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        cyc(2);
        cam_vsync = 1'b0;
        cyc(2);
        cam_href = 1'b1;
        cam_data = 8'hF8;
        cyc(1);
        check("pair before 2nd byte m_tvalid", m_tvalid, 0);
        cam_data = 8'h1F;
        exp_q.push_back({16'hF81F, 1'b1, 1'b0});
        cyc(1);
        check("pair m_tvalid", m_tvalid, 1);
        check("pair m_tdata", m_tdata, 16'hF81F);
        check("pair m_tuser", m_tuser, 1);
        cam_href = 1'b0;
        cyc(1);
        check("pair strobe width", m_tvalid, 0);
        check("pair m_tdata hold", m_tdata, 16'hF81F);
        cyc(2);
        cam_vsync = 1'b1;
        cyc(3);
        check("early vsync frame_err", frame_err, 1);
        check("short line line_err", line_err, 1);
        drain("pair");
        cam_vsync = 1'b0;
        cyc(2);
        send_line(2 * H, 0, 1'b1, 1'b0, 1'b0);
        send_line(2 * H, 1, 1'b1, 1'b0, 1'b0);
        send_line(11, 2, 1'b1, 1'b0, 1'b1);
        cam_data = 8'h5A;
        sync_rst = 1'b1;
        cyc(1);
        check("mid-frame reset m_tvalid", m_tvalid, 0);
        check("mid-frame reset m_tdata", m_tdata, 0);
        check("mid-frame reset m_tuser/m_tlast", {m_tuser, m_tlast}, 0);
        check("mid-frame reset error flags", {line_err, frame_err}, 0);
        sync_rst = 1'b0;
        u0 = n_user;
        send_line(2 * H - 12, 2, 1'b0, 1'b0, 1'b0);
        send_line(2 * H, 3, 1'b0, 1'b0, 1'b0);
        check("no tuser before vsync", n_user - u0, 0);
        drain("reset");
        run_frame(vecs[0], "after reset");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
